store_buffer_ctrl: RTL and testbench
====================================

Name: store_buffer_ctrl

Overview:
- Controller for the LSU store data buffer (SDB): a circular queue of SDB_NUM entries.
- Accepts speculative stores from the LSU and marks them committed in order on ROB retire.
- Drains committed entries to the D-cache through a req/ack handshake, and discards uncommitted entries on pipeline flush.
- On push, merges bytes from the youngest older entry with the same word address, using combine_data_unit, so each entry always holds the combined latest data.

Parameters:
- SDB_NUM, 16 (from Falco_pkg): entry count. Fixed at 16 because the combine_data_unit tree is 4 levels.
- SDB_WIDTH, 4 (from Falco_pkg): index width, log2(SDB_NUM).
- ADDR_W, 30: word-address width (byte address [31:2]).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- push_valid_i  in  1  store push request
- push_ready_o  out  1  buffer can accept a push
- push_addr_i  in  ADDR_W  store word address
- push_data_i  in  32  store data, byte-lane aligned
- push_be_i  in  4  byte enables
- push_idx_o  out  SDB_WIDTH  slot allocated to the push (equals tail)
- commit_i  in  1  retire the oldest uncommitted store
- flush_i  in  1  discard all uncommitted entries
- dc_req_o  out  1  D-cache write request
- dc_addr_o  out  32  {entry addr, 2'b00}
- dc_data_o  out  32  entry data
- dc_be_o  out  4  entry byte mask
- dc_ack_i  in  1  D-cache accepted the write
- empty_o  out  1  count == 0
- full_o  out  1  count == SDB_NUM
- count_o  out  SDB_WIDTH+1  valid entries

Behaviour:
- Pointers:
  - head = oldest entry, drain side.
  - cptr = first uncommitted entry.
  - tail = next free slot.
  - All three wrap modulo SDB_NUM.
  - Counters: count (valid entries) and ccount (committed, not yet drained).
- Reset (async, rst_n=0): all pointers and counters 0; all valid and committed bits 0; FSM IDLE; dc_req_o=0; empty_o=1; full_o=0; push_ready_o=1.
- Push:
  - push_ready_o = !full_o, combinational.
  - A push fires when push_valid_i && push_ready_o && !flush_i.
  - The entry is written at tail; tail increments. The entry is visible to match logic next cycle.
- Merge:
  - match[i] = valid[i] && addr[i]==push_addr_i. Feed combine_data_unit with push_head=tail.
  - On hit, per byte b: data[b] = push_be_i[b] ? push_data_i[b] : old.data[b]; mask = push_be_i | old.mask.
  - On no hit: raw data, mask = push_be_i.
- Commit:
  - commit_i with ccount+committed-pending < count sets committed[cptr]; cptr increments.
  - commit_i with no uncommitted entry is ignored.
- Flush:
  - tail <= cptr (after the same-cycle commit is applied); valid bits cleared for all uncommitted slots; count <= ccount.
  - A same-cycle push is dropped.
  - Committed entries and an in-flight drain are unaffected.
- Drain FSM:
  - IDLE: if committed[head] is set, latch head's addr/data/mask into output regs, dc_req_o<=1, go to REQ. The request therefore appears 1 cycle after the head becomes committed.
  - REQ: hold dc_req_o and all dc_* outputs stable until dc_ack_i. On ack: clear valid and committed at head, head++, dc_req_o<=0, back to IDLE.
  - Back-to-back drains therefore cost a minimum of 2 cycles per entry.
- Simultaneous push + drain-pop: count = count+1-1, unchanged. A match on the entry being popped still merges, because data is read combinationally before the clear.
- Full with a pop in the same cycle: push_ready_o stays 0 that cycle. There is no bypass.
- Reset mid-REQ: dc_req_o drops immediately and asynchronously; the entry is lost by design.

Optional Feature:
- SDB_MERGE_EN:
  - Defined: merge as described above.
  - Undefined: no combine_data_unit instance; every push stores raw data with mask = push_be_i. Drains are still correct because the D-cache applies byte enables in order.

Decomposition:
- Falco_pkg holds SDB_NUM, SDB_WIDTH, a sdb_entry_t struct {valid, committed, addr, data[3:0][7:0], mask} and a drain_state_e enum {IDLE, REQ}.
- One sub-module: the existing combine_data_unit, instantiated once for the push merge.
- The drain FSM stays inline.

Test Plan:
- Reset: push 3 stores, then pull rst_n low mid-REQ -> dc_req_o=0 at once, count_o=0, empty_o=1, push_ready_o=1.
- Merge: push A=0x100 data 0x11223344 be=1111, then A=0x100 data 0x000000AA be=0001 -> entry1 data=0x112233AA mask=1111. With SDB_MERGE_EN undefined -> data=0x000000AA mask=0001.
- Full: 16 pushes with no commit -> full_o=1, push_ready_o=0, count_o=16. The 17th push is not accepted.
- Commit/drain: push 2, commit 2, ack after 3 cycles -> dc_req_o rises 1 cycle after commit, dc_* stay stable until ack, the two writes come out in order, then empty_o=1.
- Flush: push 5, commit 2, flush_i together with push_valid_i -> count_o=2, tail=cptr=2, push dropped, the 2 committed entries still drain.
- Wrap: 40 push/commit/ack cycles -> pointers wrap past 15 to 0, no loss, address order preserved.

Source files
------------

// File: rtl/store_buffer_ctrl_pkg.sv
// Shared types and sizing for the LSU store data buffer controller.
// Build option SDB_MERGE_EN (see store_buffer_ctrl) enables push-time byte merging.
package store_buffer_ctrl_pkg;

  localparam int SDB_NUM   = 16;
  localparam int SDB_WIDTH = 4;
  localparam int ADDR_W    = 30;

  localparam logic [SDB_WIDTH:0] SDB_FULL = 5'd16;

  typedef struct packed {
    logic              valid;
    logic              committed;
    logic [ADDR_W-1:0] addr;
    logic [3:0][7:0]   data;
    logic [3:0]        mask;
  } sdb_entry_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } drain_state_e;

  function automatic logic [31:0] merge_bytes(input logic [31:0] new_d,
                                              input logic [31:0] old_d,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_d;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = be[b] ? new_d[b*8 +: 8] : old_d[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/store_buffer_ctrl_combine.sv
// combine_data_unit: picks the youngest matching entry older than push_head
// and overlays the pushed bytes on its data and mask.
module combine_data_unit
  import store_buffer_ctrl_pkg::*;
(
  input  logic [SDB_WIDTH-1:0]     push_head_i,
  input  logic [SDB_NUM-1:0]       match_i,
  input  logic [SDB_NUM-1:0][31:0] ent_data_i,
  input  logic [SDB_NUM-1:0][3:0]  ent_mask_i,
  input  logic [31:0]              push_data_i,
  input  logic [3:0]               push_be_i,
  output logic [31:0]              data_o,
  output logic [3:0]               mask_o
);

  logic                 hit_s;
  logic [SDB_WIDTH-1:0] sel_s;
  logic [SDB_WIDTH-1:0] idx_s;

  // Slot at age k is push_head-1-k; scanning oldest to youngest lets the youngest win.
  always_comb begin
    hit_s = 1'b0;
    sel_s = '0;
    idx_s = '0;
    for (int k = SDB_NUM - 1; k >= 0; k--) begin
      idx_s = push_head_i + ~SDB_WIDTH'(k);
      if (match_i[idx_s]) begin
        hit_s = 1'b1;
        sel_s = idx_s;
      end else begin
        sel_s = sel_s;
      end
    end
    if (hit_s) begin
      data_o = merge_bytes(push_data_i, ent_data_i[sel_s], push_be_i);
      mask_o = push_be_i | ent_mask_i[sel_s];
    end else begin
      data_o = push_data_i;
      mask_o = push_be_i;
    end
  end

endmodule

// File: rtl/store_buffer_ctrl.sv
// Store data buffer controller: in-order commit, req/ack drain to D-cache, flush.
// Define SDB_MERGE_EN to merge each push with the youngest older same-address entry.
module store_buffer_ctrl
  import store_buffer_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push_valid_i,
  output logic                 push_ready_o,
  input  logic [ADDR_W-1:0]    push_addr_i,
  input  logic [31:0]          push_data_i,
  input  logic [3:0]           push_be_i,
  output logic [SDB_WIDTH-1:0] push_idx_o,
  input  logic                 commit_i,
  input  logic                 flush_i,
  output logic                 dc_req_o,
  output logic [31:0]          dc_addr_o,
  output logic [31:0]          dc_data_o,
  output logic [3:0]           dc_be_o,
  input  logic                 dc_ack_i,
  output logic                 empty_o,
  output logic                 full_o,
  output logic [SDB_WIDTH:0]   count_o
);

  sdb_entry_t           entry_q [SDB_NUM];
  sdb_entry_t           entry_d [SDB_NUM];
  sdb_entry_t           new_entry_s;
  logic [SDB_WIDTH-1:0] head_q, head_d, cptr_q, cptr_d, tail_q, tail_d;
  logic [SDB_WIDTH:0]   count_q, count_d, ccount_q, ccount_d;
  drain_state_e         state_q, state_d;
  logic                 dc_req_q;
  logic [31:0]          dc_addr_q, dc_data_q;
  logic [3:0]           dc_be_q;
  logic                 push_fire_s, commit_fire_s, load_s, pop_s;
  logic [31:0]          wr_data_s;
  logic [3:0]           wr_mask_s;

  assign full_o       = (count_q == SDB_FULL);
  assign empty_o      = (count_q == '0);
  assign count_o      = count_q;
  assign push_ready_o = !full_o;
  assign push_idx_o   = tail_q;
  assign dc_req_o     = dc_req_q;
  assign dc_addr_o    = dc_addr_q;
  assign dc_data_o    = dc_data_q;
  assign dc_be_o      = dc_be_q;

`ifdef SDB_MERGE_EN
  logic [SDB_NUM-1:0]       match_s;
  logic [SDB_NUM-1:0][31:0] ent_data_s;
  logic [SDB_NUM-1:0][3:0]  ent_mask_s;

  // Match uses the registered contents, so a popping entry still merges.
  always_comb begin
    for (int i = 0; i < SDB_NUM; i++) begin
      match_s[i]    = entry_q[i].valid && (entry_q[i].addr == push_addr_i);
      ent_data_s[i] = entry_q[i].data;
      ent_mask_s[i] = entry_q[i].mask;
    end
  end

  combine_data_unit u_combine (
    .push_head_i (tail_q),
    .match_i     (match_s),
    .ent_data_i  (ent_data_s),
    .ent_mask_i  (ent_mask_s),
    .push_data_i (push_data_i),
    .push_be_i   (push_be_i),
    .data_o      (wr_data_s),
    .mask_o      (wr_mask_s)
  );
`else
  // Raw store; the D-cache applies byte enables in drain order.
  always_comb begin
    wr_data_s = push_data_i;
    wr_mask_s = push_be_i;
  end
`endif

  // Handshake qualification, drain FSM and pointer/counter next state.
  always_comb begin
    push_fire_s   = push_valid_i && !full_o && !flush_i;
    commit_fire_s = commit_i && (ccount_q < count_q);
    state_d       = state_q;
    load_s        = 1'b0;
    pop_s         = 1'b0;
    case (state_q)
      IDLE: begin
        if (entry_q[head_q].committed) begin
          load_s  = 1'b1;
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (dc_ack_i) begin
          pop_s   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    head_d   = head_q + SDB_WIDTH'(pop_s);
    cptr_d   = cptr_q + SDB_WIDTH'(commit_fire_s);
    ccount_d = ccount_q + (SDB_WIDTH+1)'(commit_fire_s) - (SDB_WIDTH+1)'(pop_s);
    if (flush_i) begin
      tail_d  = cptr_d;
      count_d = ccount_d;
    end else begin
      tail_d  = tail_q + SDB_WIDTH'(push_fire_s);
      count_d = count_q + (SDB_WIDTH+1)'(push_fire_s) - (SDB_WIDTH+1)'(pop_s);
    end
  end

  // Per-slot next state: push write, commit mark, pop and flush invalidation.
  always_comb begin
    new_entry_s.valid     = 1'b1;
    new_entry_s.committed = 1'b0;
    new_entry_s.addr      = push_addr_i;
    new_entry_s.data      = wr_data_s;
    new_entry_s.mask      = wr_mask_s;
    for (int i = 0; i < SDB_NUM; i++) begin
      if (push_fire_s && (tail_q == SDB_WIDTH'(i))) begin
        entry_d[i] = new_entry_s;
      end else begin
        entry_d[i] = entry_q[i];
        entry_d[i].committed = (entry_q[i].committed ||
                                (commit_fire_s && (cptr_q == SDB_WIDTH'(i)))) &&
                               !(pop_s && (head_q == SDB_WIDTH'(i)));
        entry_d[i].valid = entry_q[i].valid &&
                           !(pop_s && (head_q == SDB_WIDTH'(i))) &&
                           !(flush_i && !entry_d[i].committed);
      end
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SDB_NUM; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      entry_q <= entry_d;
    end
  end

  // Pointers, counters, FSM state and the held D-cache request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q    <= '0;
      cptr_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      ccount_q  <= '0;
      state_q   <= IDLE;
      dc_req_q  <= 1'b0;
      dc_addr_q <= 32'h0;
      dc_data_q <= 32'h0;
      dc_be_q   <= 4'h0;
    end else begin
      head_q   <= head_d;
      cptr_q   <= cptr_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      ccount_q <= ccount_d;
      state_q  <= state_d;
      if (load_s) begin
        dc_req_q  <= 1'b1;
        dc_addr_q <= {entry_q[head_q].addr, 2'b00};
        dc_data_q <= entry_q[head_q].data;
        dc_be_q   <= entry_q[head_q].mask;
      end else if (pop_s) begin
        dc_req_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer_ctrl.sv
// Self-checking bench for store_buffer_ctrl: vector table plus scoreboard of drained writes.
module tb_store_buffer_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        push_valid_i, commit_i, flush_i, dc_ack_i;
  logic [29:0] push_addr_i;
  logic [31:0] push_data_i;
  logic [3:0]  push_be_i;
  logic        push_ready_o, dc_req_o, empty_o, full_o;
  logic [3:0]  push_idx_o, dc_be_o;
  logic [31:0] dc_addr_o, dc_data_o;
  logic [4:0]  count_o;

  store_buffer_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
    .push_addr_i(push_addr_i), .push_data_i(push_data_i), .push_be_i(push_be_i),
    .push_idx_o(push_idx_o), .commit_i(commit_i), .flush_i(flush_i),
    .dc_req_o(dc_req_o), .dc_addr_o(dc_addr_o), .dc_data_o(dc_data_o),
    .dc_be_o(dc_be_o), .dc_ack_i(dc_ack_i),
    .empty_o(empty_o), .full_o(full_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  typedef struct {
    logic        pv;
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic        cm;
    logic        fl;
    int          exp_count;
    logic        exp_full;
    logic        exp_ready;
    logic        exp_req;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  ent_t        mdl[$];
  int          mcc;
  int          m_pops;
  logic [31:0] seen_data[$];
  logic [3:0]  seen_be[$];
  vec_t        vt[20];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic pv, input logic [29:0] a, input logic [31:0] d,
                              input logic cm, input logic fl, input int cnt,
                              input logic full, input logic req);
    vec_t v;
    v.pv = pv; v.a = a; v.d = d; v.be = 4'hF; v.cm = cm; v.fl = fl;
    v.exp_count = cnt; v.exp_full = full; v.exp_ready = !full; v.exp_req = req;
    return v;
  endfunction

  // One clock: drive inputs, update the reference queue, then check after the edge.
  task automatic step(input logic pv, input logic [29:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic cm, input logic fl, input logic ak);
    ent_t ne;
    logic fire;
    push_valid_i = pv; push_addr_i = a; push_data_i = d; push_be_i = be;
    commit_i = cm; flush_i = fl; dc_ack_i = ak;
    if (dc_req_o && mdl.size() > 0) begin
      chk("dc_addr", {32'h0, dc_addr_o}, {32'h0, mdl[0].addr, 2'b00});
      chk("dc_data", {32'h0, dc_data_o}, {32'h0, mdl[0].data});
      chk("dc_be", {60'h0, dc_be_o}, {60'h0, mdl[0].be});
    end
    fire = pv && (mdl.size() < 16) && !fl;
    ne.addr = a; ne.data = d; ne.be = be;
`ifdef SDB_MERGE_EN
    if (fire) begin
      for (int k = mdl.size() - 1; k >= 0; k--) begin
        if (mdl[k].addr == a) begin
          for (int b = 0; b < 4; b++) begin
            if (!be[b]) ne.data[b*8 +: 8] = mdl[k].data[b*8 +: 8];
          end
          ne.be = be | mdl[k].be;
          break;
        end
      end
    end
`endif
    if (cm && mcc < mdl.size()) mcc++;
    if (ak && dc_req_o && mdl.size() > 0) begin
      seen_data.push_back(dc_data_o);
      seen_be.push_back(dc_be_o);
      void'(mdl.pop_front());
      mcc--;
      m_pops++;
    end
    if (fl) begin
      while (mdl.size() > mcc) void'(mdl.pop_back());
    end
    if (fire) mdl.push_back(ne);
    @(posedge clk);
    #1;
    chk("count", {59'h0, count_o}, mdl.size());
    chk("empty", {63'h0, empty_o}, {63'h0, mdl.size() == 0});
    chk("full", {63'h0, full_o}, {63'h0, mdl.size() == 16});
    chk("ready", {63'h0, push_ready_o}, {63'h0, mdl.size() < 16});
    chk("push_idx", {60'h0, push_idx_o}, (m_pops + mdl.size()) % 16);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    push_valid_i = 1'b0; commit_i = 1'b0; flush_i = 1'b0; dc_ack_i = 1'b0;
    push_addr_i = 30'h0; push_data_i = 32'h0; push_be_i = 4'h0;
    #1;
    chk("rst_req", {63'h0, dc_req_o}, 64'h0);
    chk("rst_count", {59'h0, count_o}, 64'h0);
    chk("rst_empty", {63'h0, empty_o}, 64'h1);
    chk("rst_full", {63'h0, full_o}, 64'h0);
    chk("rst_ready", {63'h0, push_ready_o}, 64'h1);
    mdl.delete(); seen_data.delete(); seen_be.delete();
    mcc = 0; m_pops = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain_all(input int budget);
    int n;
    n = 0;
    while (mdl.size() > 0 && n < budget) begin
      step(1'b0, 30'h0, 32'h0, 4'h0, (mcc < mdl.size()), 1'b0, dc_req_o);
      n++;
    end
    if (n >= budget) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d entries left after %0d cycles", mdl.size(), n);
    end
    chk("drain_empty", {63'h0, empty_o}, 64'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = mk(1'b1, 30'h100, 32'h11223344, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    vt[1] = mk(1'b1, 30'h100, 32'h000000AA, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    vt[1].be = 4'h1;
    for (int i = 2; i < 16; i++) begin
      vt[i] = mk(1'b1, 30'h200 + 30'(i), 32'(i), 1'b0, 1'b0, i + 1, (i == 15), 1'b0);
    end
    vt[16] = mk(1'b1, 30'h3FF, 32'hDEADBEEF, 1'b0, 1'b0, 16, 1'b1, 1'b0);
    vt[17] = mk(1'b0, 30'h0, 32'h0, 1'b1, 1'b0, 16, 1'b1, 1'b0);
    vt[18] = mk(1'b0, 30'h0, 32'h0, 1'b1, 1'b0, 16, 1'b1, 1'b1);
    vt[19] = mk(1'b1, 30'h3FE, 32'hCAFEF00D, 1'b0, 1'b1, 2, 1'b0, 1'b1);

    do_reset();

    // Merge pair, fill to full, refused 17th push, two commits, flush with push.
    for (int r = 0; r < 20; r++) begin
      step(vt[r].pv, vt[r].a, vt[r].d, vt[r].be, vt[r].cm, vt[r].fl, 1'b0);
      chk("tbl_count", {59'h0, count_o}, vt[r].exp_count);
      chk("tbl_full", {63'h0, full_o}, {63'h0, vt[r].exp_full});
      chk("tbl_ready", {63'h0, push_ready_o}, {63'h0, vt[r].exp_ready});
      chk("tbl_req", {63'h0, dc_req_o}, {63'h0, vt[r].exp_req});
    end
    chk("flush_tail", {60'h0, push_idx_o}, 64'h2);
    drain_all(20);
    chk("tbl_drains", seen_data.size(), 64'h2);
    if (seen_data.size() == 2) begin
      chk("merge_e0_data", {32'h0, seen_data[0]}, 64'h11223344);
`ifdef SDB_MERGE_EN
      chk("merge_e1_data", {32'h0, seen_data[1]}, 64'h112233AA);
      chk("merge_e1_mask", {60'h0, seen_be[1]}, 64'hF);
`else
      chk("merge_e1_data", {32'h0, seen_data[1]}, 64'h000000AA);
      chk("merge_e1_mask", {60'h0, seen_be[1]}, 64'h1);
`endif
    end

    // Commit/drain: request one cycle after commit, held until a late ack.
    do_reset();
    step(1'b1, 30'h10, 32'hAAAA0001, 4'hF, 1'b0, 1'b0, 1'b0);
    step(1'b1, 30'h11, 32'hBBBB0002, 4'h3, 1'b0, 1'b0, 1'b0);
    step(1'b0, 30'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("cd_req_early", {63'h0, dc_req_o}, 64'h0);
    step(1'b0, 30'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("cd_req_rise", {63'h0, dc_req_o}, 64'h1);
    for (int w = 0; w < 3; w++) begin
      step(1'b0, 30'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      chk("cd_req_hold", {63'h0, dc_req_o}, 64'h1);
    end
    step(1'b0, 30'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("cd_req_drop", {63'h0, dc_req_o}, 64'h0);
    drain_all(20);
    chk("cd_drains", seen_data.size(), 64'h2);
    if (seen_data.size() == 2) begin
      chk("cd_order0", {32'h0, seen_data[0]}, 64'hAAAA0001);
      chk("cd_order1", {32'h0, seen_data[1]}, 64'hBBBB0002);
    end

    // Flush: 5 pushed, 2 committed, flush drops same-cycle push.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 30'h40 + 30'(i), 32'h4000 + 32'(i), 4'hF, 1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 30'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 30'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 30'h50, 32'h5050, 4'hF, 1'b0, 1'b1, 1'b0);
    chk("fl_count", {59'h0, count_o}, 64'h2);
    chk("fl_tail", {60'h0, push_idx_o}, 64'h2);
    drain_all(20);
    chk("fl_drains", seen_data.size(), 64'h2);
    if (seen_data.size() == 2) begin
      chk("fl_last", {32'h0, seen_data[1]}, 64'h4001);
    end

    // Reset pulled while a request is outstanding.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 30'h60 + 30'(i), 32'h6000 + 32'(i), 4'hF, 1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 30'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 30'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("mid_req_up", {63'h0, dc_req_o}, 64'h1);
    do_reset();

    // Wrap: 40 push/commit/ack rounds take every pointer past slot 15.
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 30'h300 + 30'(i), 32'h5A000000 + 32'(i), 4'hF, 1'b0, 1'b0, 1'b0);
      step(1'b0, 30'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 30'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 30'h0, 32'h0, 4'h0, 1'b0, 1'b0, dc_req_o);
    end
    drain_all(50);
    chk("wrap_drains", seen_data.size(), 64'd40);
    if (seen_data.size() == 40) begin
      chk("wrap_last", {32'h0, seen_data[39]}, 64'h5A000027);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
